// File: rtl/ram_requester_pkg.sv
// rtl/ram_requester_pkg.sv - shared widths and in-flight entry type for ram_requester
package ram_requester_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_RSP_DEPTH  = 4;

  typedef struct packed {
    logic valid;
    logic is_write;
  } inflight_t;

endpackage

// File: rtl/ram_rsp_fifo.sv
// rtl/ram_rsp_fifo.sv - first-word-fall-through response FIFO, power-of-two depth
module ram_rsp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4,
  localparam int PW = $clog2(RSP_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  not_empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push   = push & (count != CW'(RSP_DEPTH));
  assign do_pop    = pop & (count != '0);
  assign head_data = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_requester.sv
// rtl/ram_requester.sv - initiator for a latency-2 synchronous RAM with credit-checked response FIFO
// RAM_REQUESTER_WRITE_ACK_EN: when defined, accepted writes return an in-order zero response.
module ram_requester
  import ram_requester_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEFAULT_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  inflight_t             stage0;
  inflight_t             stage1;
  logic                  accept;
  logic                  track;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used;
  logic                  fifo_not_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] push_data;

  assign mem_addr     = req_addr;
  assign mem_data_in  = req_wdata;

  // Credit counts entries already queued plus responses still in the RAM pipeline.
  assign used         = {1'b0, fifo_count} + (CW+1)'(stage0.valid) + (CW+1)'(stage1.valid);
  assign req_ready    = rst_n & (used < (CW+1)'(RSP_DEPTH));
  assign accept       = req_valid & req_ready;
  assign mem_write_en = accept & req_write;

`ifdef RAM_REQUESTER_WRITE_ACK_EN
  assign track = accept;
`else
  assign track = accept & ~req_write;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0 <= '0;
      stage1 <= '0;
    end else begin
      stage0 <= '{valid: track, is_write: req_write};
      stage1 <= stage0;
    end
  end

  assign push_data = stage1.is_write ? '0 : mem_data_out;

  ram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stage1.valid),
    .push_data (push_data),
    .pop       (rsp_valid & rsp_ready),
    .head_data (fifo_head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = fifo_not_empty;
  assign rsp_rdata = rsp_valid ? fifo_head : '0;
  assign busy      = stage0.valid | stage1.valid | rsp_valid;

endmodule

// File: tb/tb_ram_requester.sv
// tb/tb_ram_requester.sv - directed and randomised checks of ram_requester against a RAM model
module tb_ram_requester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_write_en;
  logic [7:0] mem_data_out;
  logic       busy;

  int checks = 0;
  int passed = 0;

  logic [7:0] ram [256];
  logic [7:0] sb_mem [256];
  logic [7:0] addr_q;
  logic       ram_loaded = 1'b0;

  ram_requester dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered address, registered output, preloaded with addr ^ 0xA5.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
      ram_loaded <= 1'b1;
    end else if (mem_write_en) begin
      ram[mem_addr] <= mem_data_in;
    end
    addr_q       <= mem_addr;
    mem_data_out <= ram[addr_q];
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'hFF; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (mem_write_en !== 1'b0) $display("FAIL rst_mem_write_en: got %b expected 0", mem_write_en); else passed++;
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b expected 0", req_ready); else passed++;
    checks++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata: got %h expected 00", rsp_rdata); else passed++;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL rel_req_ready: got %b expected 1", req_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rel_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_write_read;
    logic       ev;
    logic [7:0] ed;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL wr_ready: got %b expected 1", req_ready); else passed++;
    checks++; if (mem_write_en !== 1'b1) $display("FAIL wr_strobe: got %b expected 1", mem_write_en); else passed++;
    checks++; if ({mem_addr, mem_data_in} !== 16'h10A5) $display("FAIL wr_passthru: got %h expected 10a5", {mem_addr, mem_data_in}); else passed++;
    @(negedge clk);
    req_write = 1'b0;
    #1;
    checks++; if (mem_write_en !== 1'b0) $display("FAIL rd_strobe: got %b expected 0", mem_write_en); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rd_ready: got %b expected 1", req_ready); else passed++;
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      ev = (k == 4);
      ed = 8'hA5;
`ifdef RAM_REQUESTER_WRITE_ACK_EN
      if (k == 3) begin ev = 1'b1; ed = 8'h00; end
`endif
      checks++; if (rsp_valid !== ev) $display("FAIL wrrd_valid_c%0d: got %b expected %b", k, rsp_valid, ev); else passed++;
      if (ev) begin
        checks++; if (rsp_rdata !== ed) $display("FAIL wrrd_data_c%0d: got %h expected %h", k, rsp_rdata, ed); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [4];
    int         idx;
    exp_d = '{8'hE4, 8'hE7, 8'hE6, 8'hE1};
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected 1", i, req_ready); else passed++;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(8'h40 + i);
    end
    @(negedge clk);
    req_addr = 8'h44;
    checks++; if (req_ready !== 1'b0) $display("FAIL stall_c4: got %b expected 0", req_ready); else passed++;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL stall_c5: got %b expected 0", req_ready); else passed++;
    checks++; if ({rsp_valid, rsp_rdata} !== 9'h1E5) $display("FAIL head_c5: got %h expected 1e5", {rsp_valid, rsp_rdata}); else passed++;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL stall_c6: got %b expected 0", req_ready); else passed++;
    checks++; if ({rsp_valid, rsp_rdata} !== 9'h1E5) $display("FAIL hold_c6: got %h expected 1e5", {rsp_valid, rsp_rdata}); else passed++;
    @(negedge clk);
    rsp_ready = 1'b1;
    checks++; if (rsp_rdata !== 8'hE5) $display("FAIL hold_c7: got %h expected e5", rsp_rdata); else passed++;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL credit_return: got %b expected 1", req_ready); else passed++;
    checks++; if (rsp_rdata !== 8'hE4) $display("FAIL order_c8: got %h expected e4", rsp_rdata); else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) $display("FAIL restall_c9: got %b expected 0", req_ready); else passed++;
    rsp_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) begin
        checks++;
        if (idx >= 4) $display("FAIL drain_extra: got %h expected none", rsp_rdata);
        else if (rsp_rdata !== exp_d[idx]) $display("FAIL drain_%0d: got %h expected %h", idx, rsp_rdata, exp_d[idx]);
        else passed++;
        idx++;
      end
      @(negedge clk);
    end
    checks++; if (idx !== 4) $display("FAIL drain_count: got %0d expected 4", idx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL drain_busy: got %b expected 0", busy); else passed++;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        req_valid = 1'b1; req_addr = 8'(8'h40 + k);
        checks++; if (req_ready !== 1'b1) $display("FAIL tput_ready_%0d: got %b expected 1", k, req_ready); else passed++;
      end else begin
        req_valid = 1'b0;
      end
      if (k >= 3 && k < 11) begin
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'(8'h40 + k - 3) ^ 8'hA5})
          $display("FAIL tput_rsp_%0d: got %h expected %h", k, {rsp_valid, rsp_rdata}, {1'b1, 8'(8'h40 + k - 3) ^ 8'hA5});
        else passed++;
      end
      if (k == 11) begin
        checks++; if (busy !== 1'b0) $display("FAIL tput_busy: got %b expected 0", busy); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight;
    int bad;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
    checks++; if (req_ready !== 1'b1) $display("FAIL rif_ready: got %b expected 1", req_ready); else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL rif_busy_pre: got %b expected 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rif_busy_rst: got %b expected 0", busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rif_stale: got %0d responses expected 0", bad); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rif_busy: got %b expected 0", busy); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rif_ready_post: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_write_ack;
    int         nrsp;
    int         first_k;
    logic [7:0] first_d;
    logic       busy_seen;
    nrsp = 0; first_k = -1; first_d = 8'hXX; busy_seen = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h77;
    checks++; if (req_ready !== 1'b1) $display("FAIL wack_ready: got %b expected 1", req_ready); else passed++;
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0;
      busy_seen |= busy;
      if (rsp_valid) begin
        if (nrsp == 0) begin first_k = k; first_d = rsp_rdata; end
        nrsp++;
      end
    end
`ifdef RAM_REQUESTER_WRITE_ACK_EN
    checks++; if (nrsp !== 1) $display("FAIL wack_count: got %0d expected 1", nrsp); else passed++;
    checks++; if (first_k !== 3) $display("FAIL wack_cycle: got %0d expected 3", first_k); else passed++;
    checks++; if (first_d !== 8'h00) $display("FAIL wack_data: got %h expected 00", first_d); else passed++;
`else
    checks++; if (nrsp !== 0) $display("FAIL wack_count: got %0d expected 0", nrsp); else passed++;
    checks++; if (busy_seen !== 1'b0) $display("FAIL wack_busy: got %b expected 0", busy_seen); else passed++;
`endif
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [7:0] d;
    for (int i = 0; i < 256; i++) sb_mem[i] = 8'(i) ^ 8'hA5;
    for (int k = 0; k < 1020; k++) begin
      @(negedge clk);
      if (k < 1000) rsp_ready = ($urandom_range(0, 3) != 0);
      else          rsp_ready = 1'b1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL rand_extra: got %h expected no response", rsp_rdata);
        else begin
          d = q.pop_front();
          if (rsp_rdata !== d) $display("FAIL rand_data: got %h expected %h", rsp_rdata, d);
          else passed++;
        end
      end
      req_valid = (k < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'h80 | 8'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      if (req_valid && req_ready) begin
        if (req_write) begin
          sb_mem[req_addr] = req_wdata;
`ifdef RAM_REQUESTER_WRITE_ACK_EN
          q.push_back(8'h00);
`endif
        end else begin
          q.push_back(sb_mem[req_addr]);
        end
        checks++; if (q.size() > 4) $display("FAIL rand_overflow: got %0d outstanding expected <= 4", q.size()); else passed++;
      end
    end
    checks++; if (q.size() !== 0) $display("FAIL rand_lost: got %0d outstanding expected 0", q.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rand_busy: got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_inflight();
    test_write_ack();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_requester.md
RAM_REQUESTER -- requirements
Module: ram_requester

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 8, RAM address width.
  DATA_WIDTH, 8, RAM data width.
  RSP_DEPTH, 4, response FIFO entries (power of two, >=2).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when high with req_valid.
  req_write  in  1  1=write, 0=read.
  req_addr  in  ADDR_WIDTH  request address.
  req_wdata  in  DATA_WIDTH  write data.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  response consumed when high with rsp_valid.
  rsp_rdata  out  DATA_WIDTH  read data, or 0 for a write ack.
  mem_addr  out  ADDR_WIDTH  to RAM address.
  mem_data_in  out  DATA_WIDTH  to RAM write data.
  mem_write_en  out  1  to RAM write strobe.
  mem_data_out  in  DATA_WIDTH  from RAM; valid 2 cycles after address.
  busy  out  1  reads in flight or FIFO non-empty.
REQ-003 Clock port SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 The block SHALL be the initiator for a synchronous single-port RAM with registered address and registered output (read latency 2).
REQ-005 mem_addr SHALL equal req_addr and mem_data_in SHALL equal req_wdata combinationally at all times.
REQ-006 mem_write_en SHALL equal req_valid & req_ready & req_write, so that only accepted writes strobe.
REQ-007 A read accepted in cycle T SHALL push mem_data_out into the response FIFO at the edge ending cycle T+2; rsp_valid SHALL rise in T+3 if the FIFO was empty.
REQ-008 In-flight reads SHALL be tracked by a 2-stage valid shift register; there are no tags, and responses SHALL return in request order.
REQ-009 req_ready SHALL be high iff (fifo_count + inflight_responses) < RSP_DEPTH, so that FIFO overflow is impossible.
REQ-010 At most one request SHALL be accepted per cycle; back-to-back accepts SHALL sustain 1 request/cycle while credit remains.
REQ-011 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-012 The FIFO SHALL be first-word-fall-through; rsp_rdata SHALL equal the head entry while rsp_valid is high.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo RSP_DEPTH.
REQ-014 rsp_valid SHALL be held and rsp_rdata SHALL remain stable while rsp_ready is low.
REQ-015 busy SHALL equal (|inflight) | rsp_valid.

Reset
REQ-016 Assertion of rst_n low SHALL immediately clear the in-flight shift register, FIFO pointers and count.
REQ-017 During reset: rsp_valid=0, busy=0, mem_write_en=0, req_ready=0; rsp_rdata=0.
REQ-018 Reads in flight at reset SHALL be discarded; no stale response appears after release.
REQ-019 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-020 Macro RAM_REQUESTER_WRITE_ACK_EN SHALL control write acknowledgement.
REQ-021 With RAM_REQUESTER_WRITE_ACK_EN defined: each accepted write SHALL occupy credit and produce one in-order response with rsp_rdata=0, following the same 2-stage pipeline as a read.
REQ-022 Without RAM_REQUESTER_WRITE_ACK_EN: writes SHALL produce no response and consume no credit, but SHALL still require req_ready.

Structure
REQ-023 Package ram_requester_pkg SHALL hold the default width constants and a typedef for the in-flight entry {valid, is_write}.
REQ-024 The response FIFO SHALL be a sub-module, ram_rsp_fifo (parameterised by DATA_WIDTH and RSP_DEPTH).

Verification
REQ-025 Write addr 0x10 data 0xA5, then read 0x10 next cycle, rsp_ready=1 -> exactly one rsp with rdata=0xA5, 3 cycles after the read accept.
REQ-026 Four reads back-to-back with rsp_ready=0 -> req_ready drops after the 4th accept; 5th request stalls; rsp order matches the address order.
REQ-027 Same as REQ-026, then rsp_ready=1 for one cycle -> one pop, req_ready returns the next cycle, throughput 1/cycle thereafter.
REQ-028 Read at addr 0x20 issued, rst_n pulsed low in cycle T+1 -> rsp_valid stays 0 after release; busy=0; req_ready=1.
REQ-029 Write to 0x30 with the macro defined -> one rsp, rdata=0x00; without the macro -> no rsp, busy stays 0.
REQ-030 Random mixed read/write traffic over 1000 cycles with random rsp_ready -> read data matches a scoreboard RAM model; no FIFO overflow, no lost or duplicated responses.
